// File: rtl/mult16_seq.sv
// Sequential 16x16 shift-and-add multiplier returning (a*b) mod 2^16.
// One shared add16 performs every accumulation; one multiplier bit is consumed per clock.
module add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] sum
);
    assign sum = x + y;
endmodule

module mult16_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        ready,
    output logic        busy,
    output logic        out_valid,
    output logic [15:0] out,
    input  logic        out_ready
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] sum;

    add16 u_add (
        .x   (acc_q),
        .y   (mcand_q),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = (EARLY_EXIT && b == 16'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) acc_d = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                // Early exit looks at the multiplier after this step's shift.
                if (cnt_q == 4'd15 || (EARLY_EXIT && mplier_d == 16'd0)) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign out       = acc_q;
endmodule
